// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase controller: FSM state encoding and
// default datapath widths.
package dds_pkg;

  localparam int unsigned DDS_PHASE_WIDTH = 32;
  localparam int unsigned DDS_ADDR_WIDTH  = 10;
  localparam int unsigned DDS_DATA_WIDTH  = 8;

  // IDLE : en low, configuration applies directly to the active registers
  // RUN  : en high, shadow empty, configuration slot free
  // PEND : en high, shadow holds a configuration waiting for the next carry
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } dds_state_e;

endpackage

// File: rtl/dds_valid_pipe.sv
// Valid/data delay line between the ROM address register and the DAC.
// vld_i tags the address presented to the ROM. The tag travels DEPTH stages,
// and the sample is captured from data_i on the same edge that moves the tag
// into the last stage. Because of this, vld_o and data_o line up, and data_o
// holds whenever no live sample is arriving. DEPTH must be at least 2.
module dds_valid_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Shift the tag along and capture data when the tag aligned with data_i is set.
  always_comb begin
    vld_d  = {vld_q[DEPTH-2:0], vld_i};
    data_d = vld_q[DEPTH-2] ? data_i : data_q;
  end

  // Pipeline registers; reset flushes every in-flight tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q;

endmodule

// File: rtl/dds_phase_ctrl.sv
// DDS phase controller: phase accumulator, glitch-free tuning-word update
// through a shadow register that commits on accumulator carry-out, ROM
// address generation with a phase offset, and DAC sample/valid alignment.
// ROM_LATENCY is supported over the range 1..2.
module dds_phase_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = DDS_PHASE_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DDS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DDS_DATA_WIDTH,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sync,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_ftw,
  input  logic [ADDR_WIDTH-1:0]  cfg_pofs,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic [DATA_WIDTH-1:0]  dac_data,
  output logic                   dac_valid,
  output logic                   wrap
);

  dds_state_e state_q, state_d;

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] ftw_act_q, ftw_act_d;
  logic [PHASE_WIDTH-1:0] ftw_shd_q, ftw_shd_d;
  logic [ADDR_WIDTH-1:0]  pofs_act_q, pofs_act_d;
  logic [ADDR_WIDTH-1:0]  pofs_shd_q, pofs_shd_d;
  logic [ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
  logic                   wrap_q, wrap_d;
  logic                   addr_vld_q;

  logic [PHASE_WIDTH:0]   sum;
  logic                   carry;
  logic                   cfg_ready_c;
  logic                   xfer;
  logic                   load_cfg;
  logic                   load_shd;

  // The carry is taken from the extended sum. sync suppresses the carry
  // because it replaces the addition.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, ftw_act_q};
    carry = en & ~sync & sum[PHASE_WIDTH];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: en low always returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (!en)       state_d = ST_IDLE;
        else if (xfer) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (!en)        state_d = ST_IDLE;
        else if (carry) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. In IDLE, or on a RUN cycle where en has already dropped, an
  // accepted configuration goes straight to the active registers. A pending
  // shadow commits on carry, or when en drops while the FSM is in PEND.
  always_comb begin
    cfg_ready_c = (state_q != ST_PEND);
    xfer        = cfg_valid & cfg_ready_c;
    load_cfg    = xfer & ((state_q == ST_IDLE) | ~en);
    load_shd    = (state_q == ST_PEND) & (~en | carry);
  end

  // Datapath next-state: accumulator, active/shadow configuration, ROM address.
  always_comb begin
    if (sync)    acc_d = '0;
    else if (en) acc_d = sum[PHASE_WIDTH-1:0];
    else         acc_d = acc_q;

    ftw_shd_d  = xfer ? cfg_ftw  : ftw_shd_q;
    pofs_shd_d = xfer ? cfg_pofs : pofs_shd_q;

    if (load_cfg) begin
      ftw_act_d  = cfg_ftw;
      pofs_act_d = cfg_pofs;
    end else if (load_shd) begin
      ftw_act_d  = ftw_shd_q;
      pofs_act_d = pofs_shd_q;
    end else begin
      ftw_act_d  = ftw_act_q;
      pofs_act_d = pofs_act_q;
    end

    rom_addr_d = acc_q[PHASE_WIDTH-1 -: ADDR_WIDTH] + pofs_act_q;
    wrap_d     = carry;
  end

  // Datapath registers. Reset discards any shadowed configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      ftw_act_q  <= '0;
      ftw_shd_q  <= '0;
      pofs_act_q <= '0;
      pofs_shd_q <= '0;
      rom_addr_q <= '0;
      wrap_q     <= 1'b0;
      addr_vld_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      ftw_act_q  <= ftw_act_d;
      ftw_shd_q  <= ftw_shd_d;
      pofs_act_q <= pofs_act_d;
      pofs_shd_q <= pofs_shd_d;
      rom_addr_q <= rom_addr_d;
      wrap_q     <= wrap_d;
      addr_vld_q <= en;
    end
  end

  // The address register adds one stage. The delay line then spans the ROM
  // read plus the DAC register.
  dds_valid_pipe #(
    .DEPTH(ROM_LATENCY + 1),
    .WIDTH(DATA_WIDTH)
  ) u_valid_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (addr_vld_q),
    .data_i(rom_data),
    .vld_o (dac_valid),
    .data_o(dac_data)
  );

  assign cfg_ready = cfg_ready_c;
  assign rom_addr  = rom_addr_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// Directed bench for dds_phase_ctrl with the default parameters and a
// one-cycle ROM model that returns rom_addr[9:2].
module tb_dds_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_ftw = '0;
  logic [9:0]  cfg_pofs = '0;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_q = '0;
  logic [7:0]  dac_data;
  logic        dac_valid;
  logic        wrap;

  int tests = 0;
  int fails = 0;
  int k = 0;
  int errs_a, errs_v, errs_d, errs_w, errs_r, nwrap, wrap_at, first_v;

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom_addr[9:2];

  dds_phase_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ftw  (cfg_ftw),
    .cfg_pofs (cfg_pofs),
    .rom_addr (rom_addr),
    .rom_data (rom_q),
    .dac_data (dac_data),
    .dac_valid(dac_valid),
    .wrap     (wrap)
  );

  typedef struct {
    logic        en;
    logic        sync;
    logic        cv;
    logic [31:0] ftw;
    logic [9:0]  pofs;
    logic [9:0]  ex_addr;
    logic        ex_wrap;
    logic        ex_ready;
    logic        ex_valid;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic e, logic s, logic v, logic [31:0] f, logic [9:0] p,
                              logic [9:0] a, logic w, logic r, logic vl);
    vec_t t;
    t.en = e; t.sync = s; t.cv = v; t.ftw = f; t.pofs = p;
    t.ex_addr = a; t.ex_wrap = w; t.ex_ready = r; t.ex_valid = vl;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic tick_to(input int t);
    while (k < t) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
  endtask

  task automatic idle_cfg(input logic [31:0] f, input logic [9:0] p);
    en = 1'b0; cfg_valid = 1'b1; cfg_ftw = f; cfg_pofs = p;
    tick();
    cfg_valid = 1'b0;
    k = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(0, 0, 1, 32'h4000_0000, 10'd0,    10'd0,   0, 1, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,         10'd0,    10'd0,   0, 1, 0);
    vecs[2]  = mk(1, 0, 0, 32'h0,         10'd0,    10'd256, 0, 1, 0);
    vecs[3]  = mk(1, 0, 0, 32'h0,         10'd0,    10'd512, 0, 1, 1);
    vecs[4]  = mk(1, 0, 0, 32'h0,         10'd0,    10'd768, 1, 1, 1);
    vecs[5]  = mk(1, 0, 0, 32'h0,         10'd0,    10'd0,   0, 1, 1);
    vecs[6]  = mk(1, 0, 1, 32'h8000_0000, 10'd0,    10'd256, 0, 0, 1);
    vecs[7]  = mk(1, 0, 0, 32'h0,         10'd0,    10'd512, 0, 0, 1);
    vecs[8]  = mk(1, 0, 0, 32'h0,         10'd0,    10'd768, 1, 1, 1);
    vecs[9]  = mk(1, 0, 0, 32'h0,         10'd0,    10'd0,   0, 1, 1);
    vecs[10] = mk(1, 0, 0, 32'h0,         10'd0,    10'd512, 1, 1, 1);
    vecs[11] = mk(1, 0, 0, 32'h0,         10'd0,    10'd0,   0, 1, 1);
    vecs[12] = mk(1, 1, 0, 32'h0,         10'd0,    10'd512, 0, 1, 1);
    vecs[13] = mk(1, 0, 0, 32'h0,         10'd0,    10'd0,   0, 1, 1);
    vecs[14] = mk(0, 0, 0, 32'h0,         10'd0,    10'd512, 0, 1, 1);
    vecs[15] = mk(0, 0, 1, 32'h4000_0000, 10'd100,  10'd512, 0, 1, 1);
    vecs[16] = mk(0, 0, 0, 32'h0,         10'd0,    10'd612, 0, 1, 0);
    vecs[17] = mk(0, 0, 1, 32'h4000_0000, 10'd1000, 10'd612, 0, 1, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,         10'd0,    10'd488, 0, 1, 0);

    // Reset values.
    do_reset();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_dac_data", dac_data, 0);
    chk("rst_dac_valid", dac_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_cfg_ready", cfg_ready, 1);

    // Cycle-by-cycle vectors, coarse FTW so the addresses step by 256.
    for (int i = 0; i < 19; i++) begin
      en = vecs[i].en; sync = vecs[i].sync; cfg_valid = vecs[i].cv;
      cfg_ftw = vecs[i].ftw; cfg_pofs = vecs[i].pofs;
      tick();
      chk($sformatf("vec%0d_addr", i), rom_addr, vecs[i].ex_addr);
      chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].ex_wrap);
      chk($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].ex_ready);
      chk($sformatf("vec%0d_valid", i), dac_valid, vecs[i].ex_valid);
    end
    cfg_valid = 1'b0; sync = 1'b0;

    // Full ramp with step 1: address sweep, a single wrap, DAC latency and data.
    do_reset();
    idle_cfg(32'h0040_0000, 10'd0);
    en = 1'b1;
    errs_a = 0; errs_v = 0; errs_d = 0; nwrap = 0; wrap_at = -1; first_v = -1;
    for (int i = 1; i <= 1030; i++) begin
      tick();
      if (rom_addr !== 10'((i - 1) % 1024)) errs_a++;
      if (wrap) begin
        nwrap++;
        if (wrap_at < 0) wrap_at = i;
      end
      if (dac_valid && first_v < 0) first_v = i;
      if (i >= 3) begin
        if (dac_valid !== 1'b1) errs_v++;
        if (dac_data !== 8'(((i - 3) % 1024) >> 2)) errs_d++;
      end
    end
    chk("ramp_addr_errors", errs_a, 0);
    chk("ramp_wrap_count", nwrap, 1);
    chk("ramp_wrap_cycle", wrap_at, 1024);
    chk("ramp_first_valid", first_v, 3);
    chk("ramp_valid_errors", errs_v, 0);
    chk("ramp_data_errors", errs_d, 0);

    // Shadowed FTW change in RUN, then an offer landing exactly on a wrap.
    do_reset();
    idle_cfg(32'h0040_0000, 10'd0);
    en = 1'b1;
    tick_to(256);
    cfg_valid = 1'b1; cfg_ftw = 32'h0080_0000; cfg_pofs = 10'd0;
    tick();
    cfg_valid = 1'b0;
    chk("pend_ready_low", cfg_ready, 0);
    tick_to(1023);
    chk("pend_step_still_1", rom_addr, 1022);
    chk("pend_ready_still_low", cfg_ready, 0);
    tick();
    chk("pend_wrap", wrap, 1);
    chk("pend_ready_back", cfg_ready, 1);
    chk("pend_addr_1024", rom_addr, 1023);
    tick();
    chk("new_step_addr0", rom_addr, 0);
    tick();
    chk("new_step_addr2", rom_addr, 2);
    tick_to(1535);
    cfg_valid = 1'b1; cfg_ftw = 32'h0040_0000; cfg_pofs = 10'd0;
    tick();
    cfg_valid = 1'b0;
    chk("wrapcyc_wrap", wrap, 1);
    chk("wrapcyc_ready_low", cfg_ready, 0);
    tick_to(1538);
    chk("wrapcyc_old_step", rom_addr, 2);
    tick_to(2047);
    chk("wrapcyc_old_period", rom_addr, 1020);
    tick();
    chk("wrapcyc_next_wrap", wrap, 1);
    chk("wrapcyc_ready_back", cfg_ready, 1);
    tick_to(2050);
    chk("wrapcyc_new_step", rom_addr, 1);

    // Phase offset plus sync landing on what would have been a carry.
    do_reset();
    idle_cfg(32'h0040_0000, 10'd512);
    en = 1'b1;
    tick();
    chk("pofs_addr_at_acc0", rom_addr, 512);
    tick_to(1023);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("sync_no_wrap", wrap, 0);
    chk("sync_addr_1024", rom_addr, 511);
    tick();
    chk("sync_addr_back_512", rom_addr, 512);
    chk("sync_no_wrap_after", wrap, 0);
    tick();
    chk("sync_addr_513", rom_addr, 513);

    // Reset in PEND: immediate output reset, discarded shadow, then FTW=0 run.
    do_reset();
    idle_cfg(32'h0040_0000, 10'd0);
    en = 1'b1;
    tick_to(10);
    cfg_valid = 1'b1; cfg_ftw = 32'h0100_0000; cfg_pofs = 10'd7;
    tick();
    cfg_valid = 1'b0;
    chk("rstpend_ready_low", cfg_ready, 0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_rom_addr", rom_addr, 0);
    chk("rstmid_dac_data", dac_data, 0);
    chk("rstmid_dac_valid", dac_valid, 0);
    chk("rstmid_wrap", wrap, 0);
    chk("rstmid_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    errs_a = 0; errs_w = 0; errs_r = 0; errs_v = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rom_addr !== 10'd0) errs_a++;
      if (wrap !== 1'b0) errs_w++;
      if (cfg_ready !== 1'b1) errs_r++;
      if (i >= 3 && dac_valid !== 1'b1) errs_v++;
    end
    chk("ftw0_addr_const", errs_a, 0);
    chk("ftw0_no_wrap", errs_w, 0);
    chk("ftw0_ready_high", errs_r, 0);
    chk("ftw0_valid_high", errs_v, 0);
    idle_cfg(32'h0040_0000, 10'd0);
    en = 1'b1;
    tick_to(5);
    chk("after_rst_step_1", rom_addr, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
